move_stack: RTL and testbench

- Path datapath directly downstream of the maze-solving controller.
- Consumes the controller's push, pop, next_move, init, load_queue and deq strobes.
- Keeps the current maze position and a LIFO of the moves taken, and returns row, column, prev_move, stack_empty and queue_empty to the controller.
- After the goal is reached, replays the stored path bottom-to-top as an answer queue, one move per deq.

---
 rtl/move_stack_if.sv | 38 +++
 rtl/move_stack.sv | 172 +++++++++++++++++
 tb/tb_move_stack.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/move_stack_if.sv
// Controller <-> move_stack strobe/status bundle.
// MOVE_STACK_REPLAY_POS_EN adds the replay position outputs.
interface move_stack_if;
  logic       init;
  logic       push;
  logic       pop;
  logic [1:0] next_move;
  logic       load_queue;
  logic       deq;
  logic [3:0] row;
  logic [3:0] column;
  logic [1:0] prev_move;
  logic       stack_empty;
  logic       queue_empty;
  logic [1:0] move_out;
  logic       move_valid;
  logic       overflow;
`ifdef MOVE_STACK_REPLAY_POS_EN
  logic [3:0] replay_row;
  logic [3:0] replay_column;
`endif

  modport master (
    output init, push, pop, next_move, load_queue, deq,
`ifdef MOVE_STACK_REPLAY_POS_EN
    input  replay_row, replay_column,
`endif
    input  row, column, prev_move, stack_empty, queue_empty, move_out, move_valid, overflow
  );

  modport slave (
    input  init, push, pop, next_move, load_queue, deq,
`ifdef MOVE_STACK_REPLAY_POS_EN
    output replay_row, replay_column,
`endif
    output row, column, prev_move, stack_empty, queue_empty, move_out, move_valid, overflow
  );
endinterface

// File: rtl/move_stack.sv
// Maze path datapath: position register, LIFO of moves, bottom-to-top replay queue.
// Optional replay position tracking via `define MOVE_STACK_REPLAY_POS_EN.
module move_stack #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PTR_W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  move_stack_if.slave  bus
);

  typedef enum logic [1:0] {MvUp = 2'd0, MvRight = 2'd1, MvLeft = 2'd2, MvDown = 2'd3} move_e;

  localparam logic [PTR_W:0] SpFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] SpOne  = (PTR_W + 1)'(1);

  // Returns {row, column} after applying one move, modulo 16.
  function automatic logic [7:0] step_pos(logic [3:0] r, logic [3:0] c, logic [1:0] m);
    logic [3:0] nr;
    logic [3:0] nc;
    nr = r;
    nc = c;
    unique case (move_e'(m))
      MvUp:    nr = r - 4'd1;
      MvDown:  nr = r + 4'd1;
      MvLeft:  nc = c - 4'd1;
      MvRight: nc = c + 4'd1;
      default: ;
    endcase
    return {nr, nc};
  endfunction

  logic [1:0]     stack_q [DEPTH];
  logic [PTR_W:0] sp_q, sp_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     col_q, col_d;
  logic [1:0]     move_out_q, move_out_d;
  logic           move_valid_q, move_valid_d;
  logic           overflow_q, overflow_d;

  logic [PTR_W:0] sp_m1;
  logic [1:0]     top_move;
  logic [1:0]     rd_move;
  logic           stack_empty;
  logic           full;
  logic           act_pp;
  logic           push_ok;
  logic           push_ovf;
  logic           pop_ok;
  logic           deq_ok;
  logic [7:0]     pos_next;

  assign sp_m1       = sp_q - SpOne;
  assign top_move    = stack_q[sp_m1[PTR_W-1:0]];
  assign rd_move     = stack_q[rd_ptr_q[PTR_W-1:0]];
  assign stack_empty = (sp_q == '0);
  assign full        = (sp_q == SpFull);
  assign pos_next    = step_pos(row_q, col_q, bus.next_move);

  // Only the highest-priority asserted strobe may act, even if it is then ignored.
  assign act_pp   = !bus.init && !bus.load_queue && (bus.push || bus.pop);
  assign push_ok  = act_pp && bus.push && !bus.pop && !full;
  assign push_ovf = act_pp && bus.push && !bus.pop && full;
  assign pop_ok   = act_pp && bus.pop && !bus.push && !stack_empty;
  assign deq_ok   = !bus.init && !bus.load_queue && !bus.push && !bus.pop && bus.deq &&
                    (rd_ptr_q < sp_q);

`ifdef MOVE_STACK_REPLAY_POS_EN
  logic [3:0] replay_row_q, replay_row_d;
  logic [3:0] replay_col_q, replay_col_d;
  logic [7:0] replay_next;

  assign replay_next = step_pos(replay_row_q, replay_col_q, rd_move);
`endif

  always_comb begin
    sp_d         = sp_q;
    rd_ptr_d     = rd_ptr_q;
    row_d        = row_q;
    col_d        = col_q;
    move_out_d   = move_out_q;
    move_valid_d = 1'b0;
    overflow_d   = overflow_q;
`ifdef MOVE_STACK_REPLAY_POS_EN
    replay_row_d = replay_row_q;
    replay_col_d = replay_col_q;
`endif
    if (bus.init) begin
      sp_d       = '0;
      rd_ptr_d   = '0;
      row_d      = '0;
      col_d      = '0;
      move_out_d = '0;
      overflow_d = 1'b0;
`ifdef MOVE_STACK_REPLAY_POS_EN
      replay_row_d = '0;
      replay_col_d = '0;
`endif
    end else if (bus.load_queue) begin
      rd_ptr_d = '0;
`ifdef MOVE_STACK_REPLAY_POS_EN
      replay_row_d = '0;
      replay_col_d = '0;
`endif
    end else if (push_ok) begin
      sp_d           = sp_q + SpOne;
      {row_d, col_d} = pos_next;
    end else if (push_ovf) begin
      overflow_d = 1'b1;
    end else if (pop_ok) begin
      sp_d           = sp_m1;
      {row_d, col_d} = pos_next;
    end else if (deq_ok) begin
      move_out_d   = rd_move;
      move_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + SpOne;
`ifdef MOVE_STACK_REPLAY_POS_EN
      {replay_row_d, replay_col_d} = replay_next;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sp_q         <= '0;
      rd_ptr_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      move_out_q   <= '0;
      move_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef MOVE_STACK_REPLAY_POS_EN
      replay_row_q <= '0;
      replay_col_q <= '0;
`endif
    end else begin
      sp_q         <= sp_d;
      rd_ptr_q     <= rd_ptr_d;
      row_q        <= row_d;
      col_q        <= col_d;
      move_out_q   <= move_out_d;
      move_valid_q <= move_valid_d;
      overflow_q   <= overflow_d;
`ifdef MOVE_STACK_REPLAY_POS_EN
      replay_row_q <= replay_row_d;
      replay_col_q <= replay_col_d;
`endif
    end
  end

  // Storage is never cleared; sp bounds which entries are meaningful.
  always_ff @(posedge clock_i) begin
    if (!reset_i && push_ok) begin
      stack_q[sp_q[PTR_W-1:0]] <= bus.next_move;
    end
  end

  assign bus.row         = row_q;
  assign bus.column      = col_q;
  assign bus.prev_move   = stack_empty ? 2'b00 : top_move;
  assign bus.stack_empty = stack_empty;
  assign bus.queue_empty = (rd_ptr_q == sp_q);
  assign bus.move_out    = move_out_q;
  assign bus.move_valid  = move_valid_q;
  assign bus.overflow    = overflow_q;
`ifdef MOVE_STACK_REPLAY_POS_EN
  assign bus.replay_row    = replay_row_q;
  assign bus.replay_column = replay_col_q;
`endif

endmodule

// File: tb/tb_move_stack.sv
// Scoreboarded random + directed bench for move_stack against a queue-based path model.
module tb_move_stack;
  localparam int unsigned Depth = 4;
  localparam int unsigned PtrW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  move_stack_if bus ();

  move_stack #(.DEPTH(Depth), .PTR_W(PtrW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the path is a plain queue, position is integer arithmetic mod 16.
  logic [1:0] m_stk[$];
  logic [1:0] exp_q[$];
  int m_row, m_col, m_rd, m_ovf, m_mo, m_mv, m_rrow, m_rcol;
  logic [1:0] mon_exp;

  task automatic move_pos(input logic [1:0] m, inout int r, inout int c);
    case (m)
      2'd0: r = (r + 15) % 16;
      2'd3: r = (r + 1) % 16;
      2'd2: c = (c + 15) % 16;
      default: c = (c + 1) % 16;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("row", 32'(bus.row), m_row);
    chk("column", 32'(bus.column), m_col);
    chk("prev_move", 32'(bus.prev_move), (m_stk.size() == 0) ? 0 : 32'(m_stk[$]));
    chk("stack_empty", 32'(bus.stack_empty), (m_stk.size() == 0) ? 1 : 0);
    chk("queue_empty", 32'(bus.queue_empty), (m_rd == m_stk.size()) ? 1 : 0);
    chk("move_out", 32'(bus.move_out), m_mo);
    chk("move_valid", 32'(bus.move_valid), m_mv);
    chk("overflow", 32'(bus.overflow), m_ovf);
`ifdef MOVE_STACK_REPLAY_POS_EN
    chk("replay_row", 32'(bus.replay_row), m_rrow);
    chk("replay_column", 32'(bus.replay_column), m_rcol);
`endif
  endtask

  task automatic model_clear();
    m_stk.delete();
    m_row = 0; m_col = 0; m_rd = 0; m_ovf = 0; m_mo = 0; m_mv = 0; m_rrow = 0; m_rcol = 0;
  endtask

  task automatic cyc(input bit r, input bit i, input bit lq, input bit ps, input bit pp,
                     input logic [1:0] nm, input bit dq);
    @(negedge clk);
    rst = r; bus.init = i; bus.load_queue = lq; bus.push = ps; bus.pop = pp;
    bus.next_move = nm; bus.deq = dq;
    m_mv = 0;
    if (r || i) begin
      model_clear();
    end else if (lq) begin
      m_rd = 0; m_rrow = 0; m_rcol = 0;
    end else if (ps && pp) begin
      // neither acts
    end else if (ps) begin
      if (m_stk.size() < Depth) begin
        m_stk.push_back(nm);
        move_pos(nm, m_row, m_col);
      end else begin
        m_ovf = 1;
      end
    end else if (pp) begin
      if (m_stk.size() > 0) begin
        void'(m_stk.pop_back());
        move_pos(nm, m_row, m_col);
      end
    end else if (dq && m_rd < m_stk.size()) begin
      m_mo = m_stk[m_rd];
      m_mv = 1;
      exp_q.push_back(m_stk[m_rd]);
      move_pos(m_stk[m_rd], m_rrow, m_rcol);
      m_rd++;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: every move_valid pulse must match the next expected replayed move.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.move_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deq_order: unexpected move_valid, move_out=%0d", bus.move_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.move_out !== mon_exp) begin
            errors++;
            $display("FAIL deq_order: got %0d expected %0d", bus.move_out, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    bus.init = 0; bus.push = 0; bus.pop = 0; bus.next_move = 0; bus.load_queue = 0; bus.deq = 0;
    model_clear();

    // Reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Push DOWN, RIGHT, RIGHT
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'd3, 0);
    cyc(0, 0, 0, 1, 0, 2'd1, 0);
    cyc(0, 0, 0, 1, 0, 2'd1, 0);
    chk("plan2_row", 32'(bus.row), 1);
    chk("plan2_col", 32'(bus.column), 2);
    chk("plan2_prev", 32'(bus.prev_move), 1);

    // Backtrack to origin, then pop on empty
    cyc(0, 0, 0, 0, 1, 2'd2, 0);
    chk("plan3_col", 32'(bus.column), 1);
    cyc(0, 0, 0, 0, 1, 2'd2, 0);
    cyc(0, 0, 0, 0, 1, 2'd0, 0);
    chk("plan3_empty", 32'(bus.stack_empty), 1);
    cyc(0, 0, 0, 0, 1, 2'd0, 0);

    // Fill to Depth, overflow, push+pop together
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0, 2'd3, 0);
    chk("plan4_ovf", 32'(bus.overflow), 1);
    chk("plan4_row", 32'(bus.row), 4);
    cyc(0, 0, 0, 1, 1, 2'd0, 0);

    // Replay DOWN, RIGHT, DOWN
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'd3, 0);
    cyc(0, 0, 0, 1, 0, 2'd1, 0);
    cyc(0, 0, 0, 1, 0, 2'd3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("plan5_qempty", 32'(bus.queue_empty), 1);
    chk("plan5_prev", 32'(bus.prev_move), 3);
`ifdef MOVE_STACK_REPLAY_POS_EN
    chk("plan5_rrow", 32'(bus.replay_row), 2);
    chk("plan5_rcol", 32'(bus.replay_column), 1);
`endif

    // Wrap, then reset during replay
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'd0, 0);
    chk("plan6_wrap", 32'(bus.row), 15);
    cyc(0, 0, 0, 1, 0, 2'd2, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("plan6_valid", 32'(bus.move_valid), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
          2'($urandom_range(0, 3)), $urandom_range(0, 99) < 50);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
